// File: rtl/adder_rr_scheduler.sv
// -----------------------------------------------------------------------------
// adder_rr_scheduler
//
// Purpose:
//    Shares one pipelined ripple-carry adder between NREQ requesters. A
//    round-robin arbiter issues at most one add per clock into an operand
//    register that feeds the adder. A tag pipeline runs alongside the adder so
//    each result is steered back to the requester that issued it.
//
// Configuration macro:
//    ADDER_SCHED_STATS_EN - when defined, op_count counts handshakes
//                           (saturating at 16'hFFFF, cleared by rst).
//                           When undefined, op_count is tied to zero.
//
// Ports (adder_rr_scheduler):
//    clk        in   1           rising-edge clock
//    rst        in   1           asynchronous, active-high reset
//    en         in   1           issue enable (in-flight ops always finish)
//    req_valid  in   NREQ        request pending per requester
//    req_a      in   NREQ*Nbits  operand A, requester i at [i*Nbits +: Nbits]
//    req_b      in   NREQ*Nbits  operand B, packed like req_a
//    req_cin    in   NREQ        carry-in per requester
//    req_ready  out  NREQ        one-hot grant
//    rsp_valid  out  NREQ        one-hot response strobe
//    rsp_sum    out  Nbits       registered result sum (holds when idle)
//    rsp_cout   out  1           registered result carry-out (holds when idle)
//    busy       out  1           any op in flight (operand stage included)
//    op_count   out  16          issued-op counter
//
// Ports (rippleCarryAdder_pipeline):
//    clk     in   1      clock (datapath only, no reset)
//    a_i     in   Nbits  operand A
//    b_i     in   Nbits  operand B
//    cin_i   in   1      carry-in
//    sum_o   out  Nbits  sum, Nstages+1 clocks after a_i/b_i/cin_i
//    cout_o  out  1      carry-out, same timing as sum_o
// -----------------------------------------------------------------------------

// Pipelined ripple-carry adder. One capture register, then Nstages stages,
// each adding one CH-bit chunk and passing its carry to the next stage.
// Latency from inputs to sum_o/cout_o is Nstages+1 clocks. The datapath is
// deliberately unreset; the scheduler masks stale data with its tags.
module rippleCarryAdder_pipeline #(
   parameter int Nstages = 2,
   parameter int Nbits   = 8
) (
   input  logic             clk,
   input  logic [Nbits-1:0] a_i,
   input  logic [Nbits-1:0] b_i,
   input  logic             cin_i,
   output logic [Nbits-1:0] sum_o,
   output logic             cout_o
);

   // Chunk width, rounded up so Nbits need not divide evenly; the padding
   // bits are zero so the carry out of bit Nbits-1 lands in sum bit Nbits.
   localparam int CH = (Nbits + Nstages - 1) / Nstages;
   localparam int PW = CH * Nstages;

   logic [PW-1:0] a_q [Nstages];
   logic [PW-1:0] b_q [Nstages];
   logic [PW-1:0] s_q [Nstages+1];
   logic [Nstages:0] c_q;

   logic [CH:0]   part_w  [Nstages];
   logic [PW-1:0] snext_w [Nstages];
   logic [PW:0]   full_w;

   genvar gi;
   generate
      for (gi = 0; gi < Nstages; gi++) begin : g_stage
         assign part_w[gi] = {1'b0, a_q[gi][gi*CH +: CH]}
                           + {1'b0, b_q[gi][gi*CH +: CH]}
                           + (CH+1)'(c_q[gi]);
         // Chunk gi of s_q[gi] is still zero, so OR-ing the chunk in is
         // equivalent to a part-select write.
         assign snext_w[gi] = s_q[gi] | (PW'(part_w[gi][CH-1:0]) << (gi*CH));
      end
   endgenerate

   always_ff @(posedge clk) begin
      a_q[0] <= PW'(a_i);
      b_q[0] <= PW'(b_i);
      s_q[0] <= '0;
      c_q[0] <= cin_i;
      for (int s = 0; s < Nstages; s++) begin
         if (s + 1 < Nstages) begin
            a_q[s+1] <= a_q[s];
            b_q[s+1] <= b_q[s];
         end
         s_q[s+1] <= snext_w[s];
         c_q[s+1] <= part_w[s][CH];
      end
   end

   assign full_w = {c_q[Nstages], s_q[Nstages]};
   assign {cout_o, sum_o} = full_w[Nbits:0];

endmodule

module adder_rr_scheduler #(
   parameter int NREQ    = 4,
   parameter int Nstages = 2,
   parameter int Nbits   = 8,
   parameter int ADD_LAT = Nstages + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*Nbits-1:0] req_a,
   input  logic [NREQ*Nbits-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [Nbits-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  busy,
   output logic [15:0]           op_count
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // ---------------- arbitration (combinational from rr_q) ----------------
   logic [IW-1:0] rr_q, rr_d;
   logic [IW-1:0] gnt_idx;
   logic          gnt_any;
   logic          hs;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      // First requester at or above the pointer, wrapping mod NREQ.
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_any && req_valid[(int'(rr_q) + k) % NREQ]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'((int'(rr_q) + k) % NREQ);
         end
      end
   end

   // The grant only ever lands on a valid requester, so a grant is a handshake.
   assign hs        = en && gnt_any;
   assign req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;

   always_comb begin
      rr_d = rr_q;
      if (hs) begin
         rr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // ---------------- operand register (adder input) ----------------
   logic [Nbits-1:0] op_a_q, op_b_q;
   logic             op_cin_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q     <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_cin_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
         if (hs) begin
            op_a_q   <= req_a[int'(gnt_idx)*Nbits +: Nbits];
            op_b_q   <= req_b[int'(gnt_idx)*Nbits +: Nbits];
            op_cin_q <= req_cin[gnt_idx];
         end
      end
   end

   // ---------------- shared adder ----------------
   logic [Nbits-1:0] add_sum;
   logic             add_cout;

   rippleCarryAdder_pipeline #(
      .Nstages (Nstages),
      .Nbits   (Nbits)
   ) u_adder (
      .clk    (clk),
      .a_i    (op_a_q),
      .b_i    (op_b_q),
      .cin_i  (op_cin_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // ---------------- tag pipeline ----------------
   // Stage 0 is aligned with the operand register; stage ADD_LAT is aligned
   // with the adder output.
   logic [ADD_LAT:0] tag_vld_q;
   logic [IW-1:0]    tag_idx_q [ADD_LAT+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_q <= '0;
         for (int k = 0; k <= ADD_LAT; k++) begin
            tag_idx_q[k] <= '0;
         end
      end else begin
         tag_vld_q    <= {tag_vld_q[ADD_LAT-1:0], hs};
         tag_idx_q[0] <= gnt_idx;
         for (int k = 1; k <= ADD_LAT; k++) begin
            tag_idx_q[k] <= tag_idx_q[k-1];
         end
      end
   end

   assign busy = |tag_vld_q;

   // ---------------- response register ----------------
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [Nbits-1:0] rsp_sum_q;
   logic             rsp_cout_q;

   assign rsp_valid_d = tag_vld_q[ADD_LAT] ? (NREQ'(1) << tag_idx_q[ADD_LAT]) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (tag_vld_q[ADD_LAT]) begin
            rsp_sum_q  <= add_sum;
            rsp_cout_q <= add_cout;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;

   // ---------------- optional statistics ----------------
`ifdef ADDER_SCHED_STATS_EN
   logic [15:0] op_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_q <= '0;
      end else if (hs && op_count_q != 16'hFFFF) begin
         op_count_q <= op_count_q + 16'd1;
      end
   end

   assign op_count = op_count_q;
`else
   assign op_count = 16'd0;
`endif

endmodule
